// File: rtl/dmem_bus_ctrl.sv
// MEM-stage data bus sequencer: captures one load/store, runs a Wishbone-style
// cycle until ack, flush or timeout, then holds one cycle so the pipeline can advance.
module dmem_bus_ctrl #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_i,
  input  logic            we_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic [DW/8-1:0] sel_i,
  input  logic            flush_i,
  output logic [DW-1:0]   rdata_o,
  output logic            stall_req_o,
  output logic            err_o,
  output logic            bus_cyc_o,
  output logic            bus_stb_o,
  output logic            bus_we_o,
  output logic [AW-1:0]   bus_addr_o,
  output logic [DW-1:0]   bus_data_o,
  output logic [DW/8-1:0] bus_sel_o,
  input  logic [DW-1:0]   bus_data_i,
  input  logic            bus_ack_i,
  output logic [1:0]      dbg_state_o
);

  // Handshake: a request is taken when req_i & ~flush_i in IDLE; the bus side
  // completes on the first rising edge with bus_cyc_o & bus_stb_o & bus_ack_i.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] cnt;
  logic       accept;
  logic       timeout_hit;

  assign dbg_state_o = state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    stall_req_o = 1'b0;
    accept      = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (req_i && !flush_i) begin
          accept      = 1'b1;
          stall_req_o = 1'b1;
          state_next  = BUSY;
        end
      end
      BUSY: begin
        stall_req_o = 1'b1;
        // Flush beats ack and timeout: the faulting access must not complete.
        if (flush_i) begin
          state_next = IDLE;
        end else if (bus_ack_i) begin
          state_next = HOLD;
        end else if (cnt == CNT_LAST) begin
          timeout_hit = 1'b1;
          state_next  = HOLD;
        end
      end
      HOLD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      rdata_o    <= '0;
      err_o      <= 1'b0;
      bus_cyc_o  <= 1'b0;
      bus_stb_o  <= 1'b0;
      bus_we_o   <= 1'b0;
      bus_addr_o <= '0;
      bus_data_o <= '0;
      bus_sel_o  <= '0;
    end else begin
      err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt        <= '0;
            bus_cyc_o  <= 1'b1;
            bus_stb_o  <= 1'b1;
            bus_we_o   <= we_i;
            bus_addr_o <= addr_i;
            bus_data_o <= wdata_i;
            bus_sel_o  <= sel_i;
          end
        end
        BUSY: begin
          cnt <= cnt + 8'd1;
          if (flush_i) begin
            bus_cyc_o  <= 1'b0;
            bus_stb_o  <= 1'b0;
            bus_we_o   <= 1'b0;
            bus_addr_o <= '0;
            bus_data_o <= '0;
            bus_sel_o  <= '0;
          end else if (bus_ack_i) begin
            bus_cyc_o <= 1'b0;
            bus_stb_o <= 1'b0;
            bus_we_o  <= 1'b0;
            if (!bus_we_o) rdata_o <= bus_data_i;
          end else if (timeout_hit) begin
            bus_cyc_o <= 1'b0;
            bus_stb_o <= 1'b0;
            err_o     <= 1'b1;
            rdata_o   <= '0;
          end
        end
        HOLD: begin
          // Return the bus to all-zero so IDLE always presents a quiet bus.
          bus_cyc_o  <= 1'b0;
          bus_stb_o  <= 1'b0;
          bus_we_o   <= 1'b0;
          bus_addr_o <= '0;
          bus_data_o <= '0;
          bus_sel_o  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
